// File: rtl/fir_pkg.sv
// Shared sample types for the FIR chain (filter stage, decimator, consumers).
package fir_pkg;

  localparam int unsigned FIR_DW = 12;

  typedef logic signed [FIR_DW-1:0] fir_sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: circular buffer with a registered head so the
// output holds its last value once the FIFO drains.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int unsigned DW    = FIR_DW,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [DW-1:0]              head_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = $clog2(DEPTH+1);

  logic [DW-1:0]   mem [DEPTH];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [LvlW-1:0] level_q, level_d;
  logic [DW-1:0]   head_q, head_d;
  logic            push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = head_q;

  // Accept/update decision, pointer and level next-state, next head value.
  always_comb begin
    pop_ok  = pop_i && !empty_o;
    // A same-cycle pop frees the slot, so a full FIFO can still take a push.
    push_ok = push_i && (!full_o || pop_ok);
    rd_nxt  = rd_q + PtrW'(1);
    wr_d    = push_ok ? wr_q + PtrW'(1) : wr_q;
    rd_d    = pop_ok ? rd_nxt : rd_q;
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LvlW'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - LvlW'(1);
    end
    head_d = head_q;
    if (pop_ok) begin
      if (level_q > LvlW'(1)) begin
        head_d = mem[rd_nxt];
      end else if (push_ok) begin
        head_d = wdata_i;
      end
    end else if (push_ok && empty_o) begin
      head_d = wdata_i;
    end
  end

  // Control state and head register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  // Storage array; contents are only ever read while valid, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// Decimate-by-DECIM stage after the FIR, buffering kept samples for a
// valid/ready consumer. Define FIR_DECIM_AVG_EN to replace drop-sampling with
// a boxcar average over each group of DECIM samples.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int unsigned DW    = FIR_DW,
  parameter int unsigned DECIM = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       Clk,
  input  logic                       Hlt_n,
  input  logic [DW-1:0]              Din,
  input  logic                       Din_vld,
  output logic [DW-1:0]              Dout,
  output logic                       Dout_vld,
  input  logic                       Dout_rdy,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       Ovf
);

  localparam int unsigned PhW = $clog2(DECIM);

  logic [PhW-1:0] phase_q, phase_d;
  logic           ovf_q, ovf_d;
  logic           keep, pop, fifo_full, fifo_empty;
  logic [DW-1:0]  push_data;

  assign keep     = Din_vld && (phase_q == PhW'(DECIM - 1));
  assign Dout_vld = !fifo_empty;
  assign pop      = Dout_vld && Dout_rdy;
  assign Ovf      = ovf_q;

`ifdef FIR_DECIM_AVG_EN
  localparam int unsigned AccW = DW + PhW;

  logic signed [AccW-1:0] acc_q, acc_d, din_ext, sum;

  // Running group sum; the kept value is the floor of the group mean.
  always_comb begin
    din_ext   = AccW'($signed(Din));
    sum       = acc_q + din_ext;
    push_data = DW'(sum >>> PhW);
    acc_d     = acc_q;
    if (Din_vld) begin
      acc_d = (phase_q == '0) ? din_ext : sum;
    end
  end

  // Accumulator register.
  always_ff @(posedge Clk or negedge Hlt_n) begin
    if (!Hlt_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign push_data = Din;
`endif

  // Phase advance and sticky overflow when a kept sample finds no room.
  always_comb begin
    phase_d = Din_vld ? phase_q + PhW'(1) : phase_q;
    ovf_d   = ovf_q || (keep && fifo_full && !pop);
  end

  // Phase counter and overflow flag.
  always_ff @(posedge Clk or negedge Hlt_n) begin
    if (!Hlt_n) begin
      phase_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Hlt_n),
    .push_i  (keep),
    .wdata_i (push_data),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (Level),
    .head_o  (Dout)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Bench for fir_decimator: reference model predicts kept samples into a
// scoreboard queue; a monitor compares on every handshake and idle cycle.
module tb_fir_decimator;
  import fir_pkg::*;

  localparam int DW    = FIR_DW;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          Clk = 1'b0;
  logic          Hlt_n = 1'b0;
  logic [DW-1:0] Din = '0;
  logic          Din_vld = 1'b0;
  logic          Dout_rdy = 1'b0;
  logic [DW-1:0] Dout;
  logic          Dout_vld;
  logic [LW-1:0] Level;
  logic          Ovf;

  int checks = 0;
  int errors = 0;

  fir_decimator #(
    .DW    (DW),
    .DECIM (DECIM),
    .DEPTH (DEPTH)
  ) dut (
    .Clk      (Clk),
    .Hlt_n    (Hlt_n),
    .Din      (Din),
    .Din_vld  (Din_vld),
    .Dout     (Dout),
    .Dout_vld (Dout_vld),
    .Dout_rdy (Dout_rdy),
    .Level    (Level),
    .Ovf      (Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: expected FIFO contents, group progress, flags.
  logic [DW-1:0] exp_q[$];
  int            grp_cnt = 0;
  int            grp_sum = 0;
  bit            m_ovf = 1'b0;
  logic [DW-1:0] last_val = '0;
  bit            do_pop;
  fir_sample_t   s_t;
  int            q;
  logic [DW-1:0] val;

  // Monitor + model: inputs are stable here; predict the next rising edge.
  always @(negedge Clk) begin
    if (!Hlt_n) begin
      exp_q.delete();
      grp_cnt  = 0;
      grp_sum  = 0;
      m_ovf    = 1'b0;
      last_val = '0;
      chk("rst_vld", int'(Dout_vld), 0);
      chk("rst_level", int'(Level), 0);
      chk("rst_dout", int'(Dout), 0);
      chk("rst_ovf", int'(Ovf), 0);
    end else begin
      chk("vld", int'(Dout_vld), int'(exp_q.size() > 0));
      chk("level", int'(Level), exp_q.size());
      chk("ovf", int'(Ovf), int'(m_ovf));
      if (exp_q.size() > 0) chk("dout", int'(Dout), int'(exp_q[0]));
      else chk("idle_dout", int'(Dout), int'(last_val));
      do_pop = (exp_q.size() > 0) && Dout_rdy;
      if (do_pop) last_val = exp_q.pop_front();
      if (Din_vld) begin
        s_t     = fir_sample_t'(Din);
        grp_sum = (grp_cnt == 0) ? int'(s_t) : grp_sum + int'(s_t);
        grp_cnt++;
        if (grp_cnt == DECIM) begin
          grp_cnt = 0;
`ifdef FIR_DECIM_AVG_EN
          q = grp_sum / DECIM;
          if ((grp_sum % DECIM) != 0 && grp_sum < 0) q = q - 1;
          val = DW'(q);
`else
          val = Din;
`endif
          if (exp_q.size() < DEPTH) exp_q.push_back(val);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
    Din_vld  = v;
    Din      = d;
    Dout_rdy = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Hlt_n   = 1'b0;
    Din_vld = 1'b0;
    @(posedge Clk);
    #1;
    Hlt_n = 1'b1;
  endtask

  int n;

  initial begin
    @(posedge Clk);
    #1;
    pulse_reset();

    // Ramp, continuously ready.
    for (int i = 0; i < 40; i++) cyc(1'b1, DW'(i), 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);

    // Gapped valid: only the 4th valid sample (40) is kept.
    pulse_reset();
    cyc(1'b1, DW'(10), 1'b1);
    cyc(1'b0, DW'($urandom), 1'b1);
    cyc(1'b1, DW'(20), 1'b1);
    cyc(1'b0, DW'($urandom), 1'b1);
    cyc(1'b1, DW'(30), 1'b1);
    cyc(1'b0, DW'($urandom), 1'b1);
    cyc(1'b1, DW'(40), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("gap_kept", int'(Dout), 40);
    repeat (2) cyc(1'b0, '0, 1'b1);

    // Overflow: ramp into a stalled consumer.
    pulse_reset();
    for (int i = 0; i < 40; i++) cyc(1'b1, DW'(i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("ovf_level", int'(Level), DEPTH);
    chk("ovf_flag", int'(Ovf), 1);
    n = 0;
    while (Dout_vld && n < 3 * DEPTH) begin
      cyc(1'b0, '0, 1'b1);
      n++;
    end
    chk("ovf_drained", int'(Dout_vld), 0);
    chk("ovf_sticky", int'(Ovf), 1);
    chk("ovf_last", int'(Dout), 31);
    pulse_reset();
    cyc(1'b0, '0, 1'b0);
    chk("ovf_cleared", int'(Ovf), 0);

    // Full with a simultaneous pop on the keep cycle.
    for (int i = 0; i < 35; i++) cyc(1'b1, DW'(100 + i), 1'b0);
    cyc(1'b1, DW'(500), 1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("fullpop_level", int'(Level), DEPTH);
    chk("fullpop_ovf", int'(Ovf), 0);
    repeat (3 * DEPTH) cyc(1'b0, '0, 1'b1);
    chk("fullpop_last", int'(Dout), 500);

    // Reset mid-group with data buffered.
    pulse_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, DW'(i + 1), 1'b0);
    Hlt_n = 1'b0;
    #1;
    chk("midrst_vld", int'(Dout_vld), 0);
    chk("midrst_level", int'(Level), 0);
    @(posedge Clk);
    #1;
    Hlt_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(200 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("midrst_kept", int'(Dout), 203);
    cyc(1'b0, '0, 1'b1);

    // Averaging corner groups (drop-sampled when averaging is disabled).
    pulse_reset();
    cyc(1'b1, DW'(-4), 1'b1);
    cyc(1'b1, DW'(-3), 1'b1);
    cyc(1'b1, DW'(-2), 1'b1);
    cyc(1'b1, DW'(-2), 1'b1);
    repeat (4) cyc(1'b1, DW'(2047), 1'b1);
    repeat (4) cyc(1'b1, DW'(-2048), 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) < 7), DW'($urandom), ($urandom_range(0, 1) == 1));
    end
    repeat (3 * DEPTH) cyc(1'b0, '0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
